// File: rtl/adder_result_stage.sv
// adder_result_stage: registers CLA adder outputs with N/Z/C/V flags into a 2-entry valid/ready FIFO.
// Optional ADDER_STAGE_SAT_EN stores a saturated result on signed overflow.
module adder_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);
  localparam int E = WIDTH + 4;
  logic [E-1:0] mem [2];
  logic [E-1:0] ent_in;
  logic [WIDTH-1:0] res_in;
  logic [1:0] count;
  logic wr_ptr, rd_ptr, push, pop, v_in;
  assign v_in = (A[WIDTH-1] == B[WIDTH-1]) && (Sum[WIDTH-1] != A[WIDTH-1]);
`ifdef ADDER_STAGE_SAT_EN
  assign res_in = v_in ? {A[WIDTH-1], {(WIDTH-1){~A[WIDTH-1]}}} : Sum;
`else
  assign res_in = Sum;
`endif
  assign ent_in = {res_in[WIDTH-1], res_in == '0, Cout, v_in, res_in};
  assign in_ready = count < 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign {flag_n, flag_z, flag_c, flag_v, result} = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      ovf_count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= ent_in;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + 2'(push) - 2'(pop);
      // clear wins over a same-cycle overflow push
      ovf_count <= ovf_clr ? '0 : (push && v_in && !(&ovf_count)) ? ovf_count + 1'b1 : ovf_count;
    end
endmodule

// File: tb/tb_adder_result_stage.sv
// tb_adder_result_stage: directed self-checking bench for adder_result_stage.
module tb_adder_result_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, Cout = 0, out_valid, out_ready = 0;
  logic [31:0] A = 0, B = 0, Sum = 0, result;
  logic flag_n, flag_z, flag_c, flag_v, ovf_clr = 0;
  logic [15:0] ovf_count;
  int errors = 0, total = 0;
`ifdef ADDER_STAGE_SAT_EN
  localparam logic [31:0] R1 = 32'h7FFFFFFF, R2 = 32'h80000000;
  localparam logic [3:0] F1 = 4'b0001, F2 = 4'b1011;
`else
  localparam logic [31:0] R1 = 32'h80000000, R2 = 32'h7FFFFFFF;
  localparam logic [3:0] F1 = 4'b1001, F2 = 4'b0011;
`endif
  adder_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sum(Sum), .Cout(Cout), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s, input logic c);
    A = a; B = b; Sum = s; Cout = c; in_valid = 1;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  initial begin
    step; step;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    chk("rst_ovf", ovf_count, 0);
    rst_n = 1;
    step;
    chk("rst_ready", in_ready, 1);
    out_ready = 1;
    drive(32'h7FFFFFFF, 1, 32'h80000000, 0); step;
    chk("t1_valid", out_valid, 1);
    chk("t1_result", result, R1);
    chk("t1_flags", {flag_n, flag_z, flag_c, flag_v}, F1);
    chk("t1_ovf", ovf_count, 1);
    drive(32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1); step;
    chk("t2_result", result, R2);
    chk("t2_flags", {flag_n, flag_z, flag_c, flag_v}, F2);
    chk("t2_ovf", ovf_count, 2);
    drive(10, -32'sd10, 0, 1); step;
    chk("t3_result", result, 0);
    chk("t3_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0110);
    chk("t3_ovf", ovf_count, 2);
    in_valid = 0; step;
    chk("t3_empty", out_valid, 0);
    out_ready = 0;
    drive(100, 90, 190, 0); step;
    chk("t4_r0", result, 190);
    chk("t4_rdy0", in_ready, 1);
    drive(3456, -32'sd8347, -32'sd4891, 0); step;
    chk("t4_full", in_ready, 0);
    chk("t4_stall0", result, 190);
    drive(10, -32'sd90, -32'sd80, 0); step;
    chk("t4_full2", in_ready, 0);
    chk("t4_stall1", result, 190);
    out_ready = 1; step;
    chk("t4_r1", result, 32'hFFFFECE5);
    chk("t4_f1", {flag_n, flag_z, flag_c, flag_v}, 4'b1000);
    chk("t4_rdy1", in_ready, 1);
    step;
    chk("t4_r2", result, 32'hFFFFFFB0);
    in_valid = 0; step;
    chk("t4_empty", out_valid, 0);
    chk("t4_ovf", ovf_count, 2);
    for (int i = 1; i <= 5; i++) begin
      drive(i, 0, i, 0); step;
      chk("t5_valid", out_valid, 1);
      chk("t5_ready", in_ready, 1);
      chk("t5_result", result, i);
    end
    for (int i = 0; i < 65540; i++) begin
      drive(32'h7FFFFFFF, 1, 32'h80000000, 0); step;
    end
    chk("sat_ovf", ovf_count, 16'hFFFF);
    ovf_clr = 1; step;
    chk("clr_ovf", ovf_count, 0);
    chk("clr_result", result, R1);
    ovf_clr = 0; step;
    chk("after_clr_ovf", ovf_count, 1);
    out_ready = 0; in_valid = 0; step;
    drive(7, 0, 7, 0); step;
    chk("pre_rst_full", in_ready, 0);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_ovf", ovf_count, 0);
    chk("async_result", result, 0);
    #2 rst_n = 1;
    step;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    out_ready = 1; step;
    chk("post_rst_stale", {out_valid, result}, 0);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
Registered output stage directly downstream of the 32-bit carry-lookahead adder. It captures A, B, Sum and Cout from the adder, derives the N/Z/C/V status flags, and buffers results in a 2-entry FIFO with valid/ready handshakes on both sides. It also keeps a saturating count of signed-overflow events. The stage decouples the purely combinational adder from downstream ALU consumers, such as the writeback or flag register.

Parameters:
WIDTH, 32, operand/result width in bits (must equal adder width)
CNT_W, 16, width of overflow event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  adder outputs and operands are valid this cycle
in_ready  out  1  stage can accept an entry this cycle
A  in  WIDTH  first operand as presented to the adder
B  in  WIDTH  second operand as presented to the adder
Sum  in  WIDTH  adder sum
Cout  in  1  adder carry out
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
result  out  WIDTH  head result
flag_n  out  1  negative: result[WIDTH-1]
flag_z  out  1  zero: result == 0
flag_c  out  1  unsigned carry: captured Cout
flag_v  out  1  signed overflow
ovf_count  out  CNT_W  number of accepted entries with V=1, saturating
ovf_clr  in  1  synchronous clear of ovf_count

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO count=0; read/write pointers=0; out_valid=0; result=0; all flags=0; ovf_count=0; in_ready=1 after reset release.
- Flag derivation at capture:
  - V = (A[W-1]==B[W-1]) && (Sum[W-1]!=A[W-1]).
  - C = Cout.
  - N and Z are computed on the stored result.
  - Flags are stored in the FIFO alongside the result. No recomputation at the output.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count < 2). It is a function of registered state only, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). result and flags are driven from the head entry. They must hold stable while out_valid=1 && out_ready=0.
- Latency: an entry pushed at edge t appears at the output after edge t when the FIFO was empty, i.e. one cycle.
- Count transitions:
  - push only: +1
  - pop only: -1
  - push and pop together (count=1 only): count unchanged, head advances
  - count=2: push impossible (in_ready=0)
  - count=0: pop impossible
- Pointers are 1 bit and wrap 1->0. Order is strictly FIFO.
- Overflow counter:
  - Increments by 1 on each push with V=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - ovf_clr has priority over a simultaneous increment. The counter reads 0 after that edge.
- Input ports are ignored when in_valid=0 or in_ready=0. No state changes.
- Reset asserted mid-operation discards all entries immediately and asynchronously. out_valid drops without waiting for a clock.

Optional Feature:
- Macro: ADDER_STAGE_SAT_EN.
- When defined, a push with V=1 stores a saturated result:
  - 2^(W-1)-1 if A[W-1]=0
  - -2^(W-1) if A[W-1]=1
- N and Z are computed on the saturated value. C and V still report the raw adder values.
- When undefined, the stored result is always Sum, and no saturation logic is synthesised.

Test Plan:
- A=32'h7FFFFFFF, B=1, Sum=32'h80000000, Cout=0, out_ready=1 -> next cycle result=32'h80000000, N=1 Z=0 C=0 V=1, ovf_count=1. With SAT_EN: result=32'h7FFFFFFF, N=0.
- A=32'h80000000, B=32'hFFFFFFFF, Sum=32'h7FFFFFFF, Cout=1 -> N=0 Z=0 C=1 V=1. With SAT_EN: result=32'h80000000, N=1.
- A=10, B=-10, Sum=0, Cout=1 -> result=0, Z=1 C=1 V=0 N=0, ovf_count unchanged.
- out_ready=0; present 100+90=190, 3456+(-8347)=-4891, 10+(-90)=-80 with in_valid=1 back-to-back -> in_ready=0 after 2 pushes and the third entry is held. Then raise out_ready -> outputs in order 190, -4891, -80, with a stable head while stalled.
- Count=1 with simultaneous push and pop for 4 cycles -> out_valid stays 1, results stream in order, count stays 1. Then assert ovf_clr together with an overflowing push -> ovf_count=0.
- With 2 entries held, pull rst_n low between clock edges -> out_valid=0, in_ready=1 after release, ovf_count=0, and no stale result appears afterwards.
